// File: rtl/pc_fetch_if.sv
// pc_fetch_if: bundle between the PC/fetch sequencer and its environment.
//   Control inputs : PCAsrc, PCBsrc, imm, rs1, commit
//   Fetch request  : req_valid, req_ready, req_addr
//   Fetch response : rsp_valid, rsp_data
//   Status outputs : inst_valid, inst, pc, misalign, instret
// master = sequencer side, slave = memory/datapath side.
interface pc_fetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            PCAsrc;
    logic            PCBsrc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic            commit;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [31:0]     rsp_data;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            misalign;
    logic [63:0]     instret;

    modport master (
        input  PCAsrc, PCBsrc, imm, rs1, commit, req_ready, rsp_valid, rsp_data,
        output req_valid, req_addr, inst_valid, inst, pc, misalign, instret
    );

    modport slave (
        output PCAsrc, PCBsrc, imm, rs1, commit, req_ready, rsp_valid, rsp_data,
        input  req_valid, req_addr, inst_valid, inst, pc, misalign, instret
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the architectural PC, issues one fetch at a time,
// holds the fetched instruction for execute and advances the PC on commit.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : pc_fetch_if master modport (selects/operands, commit strobe,
//              fetch request/response channels, pc/inst/misalign/instret)
module pc_fetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic      clk,
    input  logic      rst,
    pc_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_TRAP = 2'd3
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic            inst_valid_q;
    logic            misalign_q;
    logic [63:0]     instret_q;

    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    logic [XLEN-1:0] nxt_pc_d;

    // Next-PC adder; carry is dropped, JALR clears bit 0 before alignment check.
    always_comb begin
        add_a    = bus.PCAsrc ? bus.imm : XLEN'(4);
        add_b    = bus.PCBsrc ? bus.rs1 : pc_q;
        nxt_pc_d = add_a + add_b;
        if (bus.PCBsrc) begin
            nxt_pc_d[0] = 1'b0;
        end
    end

    // Sequencer: request, wait for response, execute until commit, or trap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            instret_q    <= 64'd0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (bus.req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.rsp_valid) begin
                        inst_q       <= bus.rsp_data;
                        inst_valid_q <= 1'b1;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (bus.commit) begin
                        instret_q    <= instret_q + 64'd1;
                        inst_valid_q <= 1'b0;
                        if (nxt_pc_d[1:0] == 2'b00) begin
                            pc_q    <= nxt_pc_d;
                            state_q <= S_REQ;
                        end else begin
                            misalign_q <= 1'b1;
                            state_q    <= S_TRAP;
                        end
                    end
                end
                default: begin
                    state_q <= S_TRAP;
                end
            endcase
        end
    end

    // Request channel is a pure decode of state and pc.
    assign bus.req_valid  = (state_q == S_REQ);
    assign bus.req_addr   = pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.pc         = pc_q;
    assign bus.misalign   = misalign_q;
    assign bus.instret    = instret_q;

endmodule
